// File: rtl/metadata_rotation_scheduler.sv
// Round-robin scheduler sharing one registered metadata rotator between NUM_REQ requesters.
// Turns the winner's byte offset into a rotation amount and holds rotator inputs until the response handshake.
module metadata_rotation_scheduler #(
  parameter int NUM_REQ               = 2,
  parameter int IDW                   = 1,
  parameter int MAXNUMWORD            = 32,
  parameter int NumberOfRotationWidth = 5,
  parameter int NumOfBytesInWord      = 4,
  parameter int ADDR_WIDTH            = 7,
  parameter int ROT_LATENCY           = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_byte_addr,
  input  logic [NUM_REQ-1:0]                req_inverse,
  output logic [NumberOfRotationWidth-1:0]  rot_num,
  output logic [IDW-1:0]                    rot_sel,
  output logic                              rot_busy,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [IDW-1:0]                    resp_id
);

  localparam int CW = $clog2(ROT_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [IDW-1:0]                   ptr_q, ptr_d;
  logic [IDW-1:0]                   rot_sel_q, rot_sel_d;
  logic [IDW-1:0]                   resp_id_q, resp_id_d;
  logic [NumberOfRotationWidth-1:0] rot_num_q, rot_num_d;

  logic                             any_s;
  logic [IDW-1:0]                   grant_s;
  logic                             can_accept_s;
  logic                             accept_s;
  logic [ADDR_WIDTH-1:0]            grant_addr_s;
  logic                             grant_inv_s;
  int                               idx_s;
  logic [NumberOfRotationWidth-1:0] rot_amt_s;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    return IDW'((sum >= NUM_REQ) ? (sum - NUM_REQ) : sum);
  endfunction

  // Round-robin search; iterating from the far end lets the nearest requester to the pointer win.
  always_comb begin
    any_s   = 1'b0;
    grant_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      grant_s = req_valid[wrap_idx(ptr_q, k)] ? wrap_idx(ptr_q, k) : grant_s;
      any_s   = any_s | req_valid[wrap_idx(ptr_q, k)];
    end
  end

  // Word index of the winner's byte offset and the forward or inverse rotation amount.
  always_comb begin
    grant_addr_s = req_byte_addr[int'(grant_s)*ADDR_WIDTH +: ADDR_WIDTH];
    grant_inv_s  = req_inverse[grant_s];
    idx_s        = (int'(grant_addr_s) / NumOfBytesInWord) % MAXNUMWORD;
    rot_amt_s    = grant_inv_s ? NumberOfRotationWidth'((MAXNUMWORD - idx_s) % MAXNUMWORD)
                               : NumberOfRotationWidth'(idx_s);
  end

  // Next-state logic; an accept in IDLE or in the RESP handshake cycle reloads the rotator inputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    rot_sel_d    = rot_sel_q;
    resp_id_d    = resp_id_q;
    rot_num_d    = rot_num_q;
    can_accept_s = 1'b0;
    case (state_q)
      IDLE: can_accept_s = 1'b1;
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          can_accept_s = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    accept_s = can_accept_s & any_s;
    if (accept_s) begin
      state_d   = WAIT;
      cnt_d     = CW'(ROT_LATENCY);
      ptr_d     = wrap_idx(grant_s, 1);
      rot_sel_d = grant_s;
      resp_id_d = grant_s;
      rot_num_d = rot_amt_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // One-hot ready to the winner; forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (accept_s && !rst) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // State and rotator-input registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      rot_sel_q <= '0;
      resp_id_q <= '0;
      rot_num_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      rot_sel_q <= rot_sel_d;
      resp_id_q <= resp_id_d;
      rot_num_q <= rot_num_d;
    end
  end

  assign rot_num    = rot_num_q;
  assign rot_sel    = rot_sel_q;
  assign resp_id    = resp_id_q;
  assign resp_valid = (state_q == RESP);
  assign rot_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_metadata_rotation_scheduler.sv
// Self-checking bench: directed plan cases plus random traffic against a transaction-level model,
// and a ROT_LATENCY=3 instance checked for response latency and input stability.
module tb_metadata_rotation_scheduler;

  localparam int N    = 2;
  localparam int IDW  = 1;
  localparam int MAXW = 32;
  localparam int NRW  = 5;
  localparam int NBW  = 4;
  localparam int AW   = 7;
  localparam int L1   = 1;
  localparam int L3   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req_valid, req_ready, req_inverse;
  logic [N*AW-1:0]   req_byte_addr;
  logic [NRW-1:0]    rot_num;
  logic [IDW-1:0]    rot_sel, resp_id;
  logic              rot_busy, resp_valid, resp_ready;

  logic [N-1:0]      b_req_valid, b_req_ready, b_req_inverse;
  logic [N*AW-1:0]   b_req_byte_addr;
  logic [NRW-1:0]    b_rot_num;
  logic [IDW-1:0]    b_rot_sel, b_resp_id;
  logic              b_rot_busy, b_resp_valid, b_resp_ready;

  metadata_rotation_scheduler #(.NUM_REQ(N), .IDW(IDW), .MAXNUMWORD(MAXW),
    .NumberOfRotationWidth(NRW), .NumOfBytesInWord(NBW), .ADDR_WIDTH(AW),
    .ROT_LATENCY(L1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_byte_addr(req_byte_addr), .req_inverse(req_inverse), .rot_num(rot_num),
    .rot_sel(rot_sel), .rot_busy(rot_busy), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id));

  metadata_rotation_scheduler #(.NUM_REQ(N), .IDW(IDW), .MAXNUMWORD(MAXW),
    .NumberOfRotationWidth(NRW), .NumOfBytesInWord(NBW), .ADDR_WIDTH(AW),
    .ROT_LATENCY(L3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_byte_addr(b_req_byte_addr), .req_inverse(b_req_inverse), .rot_num(b_rot_num),
    .rot_sel(b_rot_sel), .rot_busy(b_rot_busy), .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready), .resp_id(b_resp_id));

  int n_total = 0;
  int n_bad   = 0;

  // Transaction-level model: busy flag plus the cycle of the last accept.
  bit           m_busy;
  int           m_acc_cyc, m_ptr, m_rot_num, m_rot_sel, m_resp_id;
  int           cyc;
  bit [N-1:0]   m_accepted;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rot_amount(input int addr, input bit inv);
    int idx;
    idx = (addr / NBW) % MAXW;
    return inv ? (MAXW - idx) % MAXW : idx;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_acc_cyc = 0; m_ptr = 0;
    m_rot_num = 0; m_rot_sel = 0; m_resp_id = 0;
    m_accepted = '0;
  endtask

  // Called just after a negedge with inputs driven; checks, advances the model, ends on the next negedge.
  task automatic step();
    bit rv_exp, can, any;
    int g, exp_ready;
    #1;
    rv_exp = m_busy && (cyc >= m_acc_cyc + L1);
    can    = !m_busy || (rv_exp && resp_ready);
    any = 1'b0; g = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (!any && req_valid[c]) begin
        any = 1'b1; g = c;
      end
    end
    exp_ready = (can && any) ? (1 << g) : 0;
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("resp_valid", resp_valid, rv_exp);
    check_eq("rot_busy", rot_busy, m_busy);
    check_eq("rot_num", rot_num, m_rot_num);
    check_eq("rot_sel", rot_sel, m_rot_sel);
    check_eq("resp_id", resp_id, m_resp_id);
    m_accepted = '0;
    if (rv_exp && resp_ready) m_busy = 1'b0;
    if (can && any) begin
      m_busy     = 1'b1;
      m_acc_cyc  = cyc + 1;
      m_rot_num  = rot_amount(int'(req_byte_addr[g*AW +: AW]), req_inverse[g]);
      m_rot_sel  = g;
      m_resp_id  = g;
      m_ptr      = (g + 1) % N;
      m_accepted[g] = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input int addr, input bit inv);
    req_valid[r] = 1'b1;
    req_byte_addr[r*AW +: AW] = AW'(addr);
    req_inverse[r] = inv;
  endtask

  // Single transaction from requester r; checks the registered rotation amount after the accept.
  task automatic txn(input int r, input int addr, input bit inv, input int exp_rot, input string tag);
    int guard;
    set_req(r, addr, inv);
    guard = 0;
    while (!m_accepted[r] && guard < 20) begin
      step();
      guard++;
    end
    check_eq({tag, "_accepted"}, m_accepted[r], 1);
    req_valid[r] = 1'b0;
    check_eq({tag, "_rot_num"}, rot_num, exp_rot);
    check_eq({tag, "_rot_sel"}, rot_sel, r);
    resp_ready = 1'b1;
    guard = 0;
    while (m_busy && guard < 20) begin
      step();
      guard++;
    end
    check_eq({tag, "_done"}, m_busy, 0);
    resp_ready = 1'b0;
  endtask

  initial begin
    int guard, n;
    rst = 1'b1;
    req_valid = '0; req_inverse = '0; req_byte_addr = '0; resp_ready = 1'b0;
    b_req_valid = '0; b_req_inverse = '0; b_req_byte_addr = '0; b_resp_ready = 1'b0;
    cyc = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_eq("rst_rot_num", rot_num, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_rot_busy", rot_busy, 0);
    check_eq("rst_b_busy", b_rot_busy, 0);
    rst = 1'b0;

    // Plan cases: forward, inverse, inverse of zero, non-aligned high offset.
    txn(0, 'h0C, 1'b0, 3, "fwd");
    txn(1, 'h0C, 1'b1, 29, "inv");
    txn(1, 'h00, 1'b1, 0, "inv0");
    txn(1, 'h7D, 1'b0, 31, "wrap");

    // Both requesting, resp_ready high: alternating back-to-back grants.
    set_req(0, 'h10, 1'b0);
    set_req(1, 'h24, 1'b1);
    resp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_accepted != '0) n++;
    end
    check_eq("b2b_accepts", n, 5);
    req_valid = '0;
    step(); step();

    // Response stalled: outputs held, no ready despite pending req0.
    resp_ready = 1'b0;
    set_req(0, 'h08, 1'b0);
    step();
    req_valid[0] = 1'b0;
    step();
    set_req(0, 'h2C, 1'b1);
    for (int i = 0; i < 5; i++) step();
    check_eq("stall_resp_valid", resp_valid, 1);
    check_eq("stall_rot_num", rot_num, 2);
    resp_ready = 1'b1;
    step();
    check_eq("stall_grant", m_accepted, 1);
    req_valid = '0;
    step(); step();
    resp_ready = 1'b0;

    // Asynchronous reset in WAIT.
    set_req(1, 'h44, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_req_ready", req_ready, 0);
    check_eq("arst_rot_busy", rot_busy, 0);
    check_eq("arst_rot_num", rot_num, 0);
    check_eq("arst_rot_sel", rot_sel, 0);
    check_eq("arst_resp_id", resp_id, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req_valid = '0;
    step(); step();
    check_eq("arst_no_resp", resp_valid, 0);
    set_req(0, 'h04, 1'b0);
    set_req(1, 'h08, 1'b0);
    step();
    check_eq("arst_grant0", m_accepted, 1);
    req_valid = '0;
    resp_ready = 1'b1;
    step(); step(); step();

    // Random traffic; addresses change only when a requester is idle or was just accepted.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        if (m_accepted[r] || !req_valid[r]) begin
          req_valid[r] = ($urandom_range(2) != 0);
          req_byte_addr[r*AW +: AW] = AW'($urandom);
          req_inverse[r] = 1'($urandom);
        end else if ($urandom_range(9) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(2) != 0);
      step();
    end
    req_valid = '0;
    resp_ready = 1'b1;
    step(); step(); step();

    // ROT_LATENCY=3 instance: latency and stable rotator inputs.
    b_req_valid[0] = 1'b1;
    b_req_byte_addr[0 +: AW] = AW'(8'h14);
    b_req_inverse[0] = 1'b1;
    guard = 0;
    #1;
    while (!b_req_ready[0] && guard < 10) begin
      @(negedge clk); #1;
      guard++;
    end
    check_eq("l3_ready", b_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    b_req_valid = '0;
    n = 0;
    while (!b_resp_valid && n < 10) begin
      check_eq("l3_rot_num_wait", b_rot_num, 27);
      check_eq("l3_busy_wait", b_rot_busy, 1);
      @(posedge clk); @(negedge clk);
      n++;
    end
    check_eq("l3_latency", n, L3);
    check_eq("l3_rot_num_resp", b_rot_num, 27);
    check_eq("l3_rot_sel", b_rot_sel, 0);
    check_eq("l3_resp_id", b_resp_id, 0);
    b_resp_ready = 1'b1;
    @(negedge clk);
    check_eq("l3_idle", b_rot_busy, 0);
    check_eq("l3_resp_drop", b_resp_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/metadata_rotation_scheduler.md
Name: metadata_rotation_scheduler

Overview:
- Shares a single metadata rotator (bit-width, mid, conv and isBool arrays) between NUM_REQ requesters, such as the quantizer and dequantizer paths.
- Arbitrates round-robin and converts each requester's byte offset into a rotation amount, with an optional inverse direction.
- Drives the rotator's rotation-amount and source-select inputs and holds them stable for the rotator's registered latency.
- Presents a valid/ready response that tells the winning requester the rotated arrays are valid.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
IDW, 1, requester-ID width (clog2(NUM_REQ), minimum 1)
MAXNUMWORD, 32, words per rotated array (power of 2)
NumberOfRotationWidth, 5, log2(MAXNUMWORD)
NumOfBytesInWord, 4, bytes per word (power of 2)
ADDR_WIDTH, 7, byte-offset width per requester
ROT_LATENCY, 1, rotator output register depth in cycles (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  request per requester
req_ready  out  NUM_REQ  one-hot accept; accept = req_valid[i] & req_ready[i]
req_byte_addr  in  NUM_REQ*ADDR_WIDTH  byte offset; slice i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_inverse  in  NUM_REQ  1 = inverse rotation (undo a prior rotation)
rot_num  out  NumberOfRotationWidth  rotation amount to the rotator
rot_sel  out  IDW  source-select for the metadata mux feeding the rotator
rot_busy  out  1  high from accept until response handshake
resp_valid  out  1  rotated arrays valid for requester resp_id
resp_ready  in  1  consumer accepts the response
resp_id  out  IDW  ID of the served requester

Behaviour:
- Reset:
  - State IDLE; rot_num=0, rot_sel=0, resp_id=0.
  - resp_valid=0, rot_busy=0, req_ready=0.
  - Round-robin pointer = 0.
  - Reset mid-operation aborts any transaction immediately; no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant requester g, the first set bit searching from pointer upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - Accept edge:
    - Register rot_sel=g and resp_id=g.
    - Register rot_num = R (see below).
    - Pointer = (g+1) mod NUM_REQ.
    - cnt = ROT_LATENCY; go to WAIT.
  - No req_valid: stay in IDLE, outputs unchanged.
- Rotation amount:
  - idx = (req_byte_addr_g / NumOfBytesInWord) mod MAXNUMWORD; non-word-aligned low bits are ignored.
  - R = idx when inverse=0.
  - R = (MAXNUMWORD - idx) mod MAXNUMWORD when inverse=1; idx=0 gives R=0.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1, go to RESP at the next edge. WAIT therefore lasts exactly ROT_LATENCY cycles.
  - req_ready=0 throughout.
- RESP:
  - resp_valid=1; it stays high, and resp_id and rot_num stay unchanged, until resp_ready.
  - On resp_ready with no pending req_valid: go to IDLE; resp_valid drops next cycle.
  - On resp_ready with a pending req_valid: arbitrate and assert req_ready in the same cycle (back-to-back). The accept follows the same rules as IDLE and goes directly to WAIT.
- Timing:
  - Latency from accept edge to resp_valid high is ROT_LATENCY cycles.
  - Peak throughput is one transaction per ROT_LATENCY+1 cycles.
- Stability: rot_num and rot_sel change only on accept edges, so the rotator's inputs are stable for the whole WAIT and RESP window.
- rot_busy = (state != IDLE).
- Requesters must hold req_byte_addr and req_inverse stable while req_valid is high. A withdrawn request, where req_valid drops before accept, is simply not granted.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 other transactions.
- req_ready is never asserted while resp_valid is high and resp_ready is low.

Test Plan:
- Reset, then single request from req0 with addr=0x0C, inverse=0 -> req_ready[0] pulses for 1 cycle; rot_num=3, rot_sel=0; resp_valid rises 1 cycle after accept (ROT_LATENCY=1) with resp_id=0; rot_busy drops after resp_ready.
- Inverse and wrap: req1 with addr=0x0C, inverse=1 -> rot_num=29. With addr=0x00, inverse=1 -> rot_num=0. With addr=0x7D, inverse=0 -> idx=31, rot_num=31.
- Both requesters valid continuously with resp_ready tied high -> grants alternate 0,1,0,1. Accepts occur back-to-back in the RESP-handshake cycle, one transaction every 2 cycles.
- resp_ready held low for 5 cycles in RESP -> resp_valid, resp_id and rot_num constant; req_ready=0 despite pending req0; grant to req0 occurs in the cycle resp_ready rises.
- rst asserted asynchronously mid-WAIT -> all outputs 0 immediately; no resp_valid after release; next grant goes to req0.
- ROT_LATENCY=3 build -> resp_valid first high exactly 3 cycles after the accept edge; rot_num unchanged across the whole window.
